// File: rtl/pc_fetch_unit.sv
// pc_fetch_unit: owns the fetch PC, the imem req/ready handshake and the IF/ID
// register, applying delay-slot branch redirects and a highest-priority flush.
module pc_fetch_unit #(
  parameter logic [31:0] RESET_PC  = 32'h0040_0000,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall,
  input  logic        is_branch,
  input  logic [31:0] branch_pc,
  input  logic        flush,
  input  logic [31:0] flush_pc,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ready,
  input  logic [31:0] imem_rdata,
  output logic [31:0] pc_out,
  output logic [31:0] id_instr,
  output logic [31:0] id_pc,
  output logic        id_valid
);

  typedef enum logic {FETCH, HOLD} state_t;

  state_t      state_q, state_d;
  logic [31:0] pc_q;
  logic [31:0] hold_instr_q;
  logic [31:0] redirect_target_q;
  logic [31:0] discard_addr_q;
  logic [31:0] id_instr_q;
  logic [31:0] id_pc_q;
  logic        id_valid_q;
  logic        redirect_pending_q;
  logic        discard_q;

  logic        complete;
  logic        transfer;
  logic        accept;
  logic [31:0] transfer_instr;
  logic [31:0] next_pc;

  always_ff @(posedge clk) begin
    if (rst) state_q <= FETCH;
    else     state_q <= state_d;
  end

  // A transfer moves one fetched word (live or held) into IF/ID and advances the PC.
  always_comb begin
    state_d        = state_q;
    imem_req       = 1'b0;
    transfer       = 1'b0;
    transfer_instr = imem_rdata;
    case (state_q)
      FETCH: begin
        imem_req = !rst;
        if (flush) begin
          state_d = FETCH;
        end else if (imem_req && imem_ready && !discard_q) begin
          if (stall) state_d = HOLD;
          else       transfer = 1'b1;
        end
      end
      HOLD: begin
        transfer_instr = hold_instr_q;
        if (flush) begin
          state_d = FETCH;
        end else if (!stall) begin
          transfer = 1'b1;
          state_d  = FETCH;
        end
      end
      default: state_d = FETCH;
    endcase
  end

  assign complete  = imem_req & imem_ready;
  assign accept    = is_branch & id_valid_q & ~stall & ~flush;
  assign next_pc   = redirect_pending_q ? redirect_target_q :
                     accept             ? branch_pc         : pc_q + 32'd4;
  // While discarding, the request stays on the abandoned address until it completes.
  assign imem_addr = discard_q ? discard_addr_q : pc_q;
  assign pc_out    = pc_q;
  assign id_instr  = id_instr_q;
  assign id_pc     = id_pc_q;
  assign id_valid  = id_valid_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      pc_q               <= RESET_PC;
      hold_instr_q       <= NOP_INSTR;
      redirect_target_q  <= 32'h0;
      discard_addr_q     <= 32'h0;
      id_instr_q         <= NOP_INSTR;
      id_pc_q            <= 32'h0;
      id_valid_q         <= 1'b0;
      redirect_pending_q <= 1'b0;
      discard_q          <= 1'b0;
    end else if (flush) begin
      pc_q               <= flush_pc;
      id_valid_q         <= 1'b0;
      id_instr_q         <= NOP_INSTR;
      redirect_pending_q <= 1'b0;
      if (state_q == FETCH && !complete) begin
        discard_q <= 1'b1;
        if (!discard_q) discard_addr_q <= pc_q;
      end else begin
        discard_q <= 1'b0;
      end
    end else begin
      if (complete && discard_q) discard_q <= 1'b0;
      if (complete && !discard_q && stall) hold_instr_q <= imem_rdata;
      if (transfer) begin
        id_instr_q <= transfer_instr;
        id_pc_q    <= pc_q;
        id_valid_q <= 1'b1;
        pc_q       <= next_pc;
      end else if (!stall) begin
        id_valid_q <= 1'b0;
        id_instr_q <= NOP_INSTR;
      end
      // The delay slot is the word at pc_q; its transfer consumes any redirect.
      if (transfer) begin
        redirect_pending_q <= 1'b0;
      end else if (accept) begin
        redirect_pending_q <= 1'b1;
        redirect_target_q  <= branch_pc;
      end
    end
  end

endmodule

// File: tb/tb_pc_fetch_unit.sv
// Testbench for pc_fetch_unit: directed scenarios plus randomized traffic,
// checked against a transaction-level model of fetch, hold and redirect.
module tb_pc_fetch_unit;

  localparam logic [31:0] RESET_PC  = 32'h0040_0000;
  localparam logic [31:0] NOP_INSTR = 32'h0000_0000;

  logic        clk;
  logic        rst;
  logic        stall;
  logic        is_branch;
  logic [31:0] branch_pc;
  logic        flush;
  logic [31:0] flush_pc;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ready;
  logic [31:0] imem_rdata;
  logic [31:0] pc_out;
  logic [31:0] id_instr;
  logic [31:0] id_pc;
  logic        id_valid;

  int checks;
  int failures;
  bit armed;

  pc_fetch_unit #(.RESET_PC(RESET_PC), .NOP_INSTR(NOP_INSTR)) dut (
    .clk(clk), .rst(rst), .stall(stall), .is_branch(is_branch),
    .branch_pc(branch_pc), .flush(flush), .flush_pc(flush_pc),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_ready(imem_ready),
    .imem_rdata(imem_rdata), .pc_out(pc_out), .id_instr(id_instr),
    .id_pc(id_pc), .id_valid(id_valid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] memWord(input logic [31:0] a);
    return {a[15:0], ~a[31:16]} ^ 32'h1357_9BDF;
  endfunction

  assign imem_rdata = memWord(imem_addr);

  // Reference model: one outstanding fetch, at most one parked word, one pending redirect.
  logic [31:0] m_pc, m_id_instr, m_id_pc, m_target, m_disc_addr;
  logic        m_id_valid, m_pend, m_disc;
  logic [31:0] held[$];

  function automatic logic expReq();
    return !rst && held.size() == 0;
  endfunction

  function automatic logic [31:0] expAddr();
    return m_disc ? m_disc_addr : m_pc;
  endfunction

  task automatic modelStep();
    logic        done, have, take;
    logic [31:0] word;
    done = expReq() && imem_ready;
    word = memWord(expAddr());
    if (rst) begin
      m_pc = RESET_PC; m_id_instr = NOP_INSTR; m_id_pc = 32'h0; m_id_valid = 1'b0;
      m_pend = 1'b0; m_target = 32'h0; m_disc = 1'b0; m_disc_addr = 32'h0;
      held.delete();
    end else if (flush) begin
      if (held.size() == 0 && !done) begin
        if (!m_disc) m_disc_addr = m_pc;
        m_disc = 1'b1;
      end else begin
        m_disc = 1'b0;
      end
      m_pc = flush_pc; m_id_valid = 1'b0; m_id_instr = NOP_INSTR; m_pend = 1'b0;
      held.delete();
    end else begin
      take = is_branch && m_id_valid && !stall;
      have = held.size() != 0 || (done && !m_disc);
      if (held.size() != 0) word = held[0];
      if (done && m_disc) m_disc = 1'b0;
      if (have && !stall) begin
        m_id_instr = word; m_id_pc = m_pc; m_id_valid = 1'b1;
        m_pc = m_pend ? m_target : (take ? branch_pc : m_pc + 32'd4);
        m_pend = 1'b0;
        held.delete();
      end else begin
        if (have && held.size() == 0) held.push_back(word);
        if (!stall) begin
          m_id_valid = 1'b0; m_id_instr = NOP_INSTR;
          if (take) begin m_pend = 1'b1; m_target = branch_pc; end
        end
      end
    end
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One clock: drive inputs, compare against the model, advance both at the edge.
  task automatic applyStimulus(input logic r, input logic s, input logic b,
                               input logic [31:0] bpc, input logic f,
                               input logic [31:0] fpc, input logic rdy);
    @(negedge clk);
    rst = r; stall = s; is_branch = b; branch_pc = bpc;
    flush = f; flush_pc = fpc; imem_ready = rdy;
    #1;
    if (armed) begin
      checkOutput("model_imem_req", 32'(imem_req), 32'(expReq()));
      checkOutput("model_imem_addr", imem_addr, expAddr());
      checkOutput("model_pc_out", pc_out, m_pc);
      checkOutput("model_id_instr", id_instr, m_id_instr);
      checkOutput("model_id_pc", id_pc, m_id_pc);
      checkOutput("model_id_valid", 32'(id_valid), 32'(m_id_valid));
    end
    modelStep();
    @(posedge clk);
    #1;
  endtask

  task automatic step(input logic s, input logic rdy);
    applyStimulus(1'b0, s, 1'b0, 32'h0, 1'b0, 32'h0, rdy);
  endtask

  initial begin
    logic        r_rst, r_stall, r_br, r_fl, r_rdy;
    logic [31:0] r_bpc, r_fpc;
    checks = 0; failures = 0; armed = 1'b0; m_disc = 1'b0;
    rst = 1'b1; stall = 1'b0; is_branch = 1'b0; branch_pc = 32'h0;
    flush = 1'b0; flush_pc = 32'h0; imem_ready = 1'b0;

    applyStimulus(1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
    armed = 1'b1;
    applyStimulus(1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b1);
    checkOutput("rst_pc_out", pc_out, RESET_PC);
    checkOutput("rst_imem_req", 32'(imem_req), 32'h0);
    checkOutput("rst_id_valid", 32'(id_valid), 32'h0);
    checkOutput("rst_id_pc", id_pc, 32'h0);
    checkOutput("rst_id_instr", id_instr, NOP_INSTR);

    // Sequential zero-wait fetch
    step(1'b0, 1'b1);
    checkOutput("seq_addr1", imem_addr, 32'h0040_0004);
    checkOutput("seq_idpc0", id_pc, 32'h0040_0000);
    checkOutput("seq_valid", 32'(id_valid), 32'h1);
    step(1'b0, 1'b1);
    checkOutput("seq_addr2", imem_addr, 32'h0040_0008);
    checkOutput("seq_idpc1", id_pc, 32'h0040_0004);
    for (int i = 0; i < 3; i++) step(1'b0, 1'b1);
    checkOutput("br_idpc_branch", id_pc, 32'h0040_0010);

    // Taken branch with zero-wait delay slot (bypass)
    applyStimulus(1'b0, 1'b0, 1'b1, 32'h0040_0100, 1'b0, 32'h0, 1'b1);
    checkOutput("br_idpc_slot", id_pc, 32'h0040_0014);
    checkOutput("br_addr_target", imem_addr, 32'h0040_0100);
    step(1'b0, 1'b1);
    checkOutput("br_idpc_target", id_pc, 32'h0040_0100);

    // Taken branch with slow delay-slot fetch
    for (int i = 0; i < 4; i++) step(1'b0, 1'b1);
    checkOutput("slow_idpc_branch", id_pc, 32'h0040_0110);
    applyStimulus(1'b0, 1'b0, 1'b1, 32'h0040_0200, 1'b0, 32'h0, 1'b0);
    checkOutput("slow_bubble1", 32'(id_valid), 32'h0);
    checkOutput("slow_addr_slot", imem_addr, 32'h0040_0114);
    step(1'b0, 1'b0);
    checkOutput("slow_bubble2", 32'(id_valid), 32'h0);
    step(1'b0, 1'b1);
    checkOutput("slow_idpc_slot", id_pc, 32'h0040_0114);
    checkOutput("slow_addr_target", imem_addr, 32'h0040_0200);

    // Stall while a fetch completes
    step(1'b1, 1'b1);
    checkOutput("stall_req", 32'(imem_req), 32'h0);
    checkOutput("stall_idpc", id_pc, 32'h0040_0114);
    for (int i = 0; i < 3; i++) begin
      step(1'b1, 1'b1);
      checkOutput("stall_req_hold", 32'(imem_req), 32'h0);
      checkOutput("stall_idpc_hold", id_pc, 32'h0040_0114);
    end
    step(1'b0, 1'b0);
    checkOutput("stall_release_pc", id_pc, 32'h0040_0200);
    checkOutput("stall_release_instr", id_instr, memWord(32'h0040_0200));
    checkOutput("stall_release_req", 32'(imem_req), 32'h1);
    step(1'b0, 1'b1);
    checkOutput("stall_next_pc", id_pc, 32'h0040_0204);

    // Flush with an outstanding fetch
    applyStimulus(1'b0, 1'b0, 1'b0, 32'h0, 1'b1, 32'h0040_0020, 1'b1);
    checkOutput("fl_setup_addr", imem_addr, 32'h0040_0020);
    applyStimulus(1'b0, 1'b0, 1'b0, 32'h0, 1'b1, 32'h8000_0180, 1'b0);
    checkOutput("fl_addr_stays", imem_addr, 32'h0040_0020);
    checkOutput("fl_pc_out", pc_out, 32'h8000_0180);
    checkOutput("fl_valid0", 32'(id_valid), 32'h0);
    step(1'b0, 1'b0);
    checkOutput("fl_addr_stays2", imem_addr, 32'h0040_0020);
    checkOutput("fl_valid1", 32'(id_valid), 32'h0);
    step(1'b0, 1'b1);
    checkOutput("fl_addr_new", imem_addr, 32'h8000_0180);
    checkOutput("fl_valid2", 32'(id_valid), 32'h0);
    step(1'b0, 1'b1);
    checkOutput("fl_idpc", id_pc, 32'h8000_0180);

    // Reset during an outstanding fetch with a pending redirect
    applyStimulus(1'b0, 1'b0, 1'b1, 32'h0000_1000, 1'b0, 32'h0, 1'b0);
    applyStimulus(1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
    checkOutput("mrst_pc", pc_out, RESET_PC);
    checkOutput("mrst_valid", 32'(id_valid), 32'h0);
    checkOutput("mrst_idpc", id_pc, 32'h0);
    checkOutput("mrst_instr", id_instr, NOP_INSTR);
    step(1'b0, 1'b0);
    checkOutput("mrst_addr", imem_addr, RESET_PC);
    checkOutput("mrst_req", 32'(imem_req), 32'h1);
    step(1'b0, 1'b1);
    checkOutput("mrst_no_redirect", imem_addr, 32'h0040_0004);

    // PC wrap at the top of the address space
    applyStimulus(1'b0, 1'b0, 1'b0, 32'h0, 1'b1, 32'hFFFF_FFFC, 1'b1);
    checkOutput("wrap_addr_top", imem_addr, 32'hFFFF_FFFC);
    step(1'b0, 1'b1);
    checkOutput("wrap_addr_zero", imem_addr, 32'h0000_0000);
    checkOutput("wrap_idpc", id_pc, 32'hFFFF_FFFC);
    checkOutput("wrap_instr", id_instr, memWord(32'hFFFF_FFFC));

    // Randomized traffic against the model
    for (int i = 0; i < 400; i++) begin
      r_rst   = ($urandom_range(0, 63) == 0);
      r_stall = ($urandom_range(0, 99) < 30);
      r_br    = ($urandom_range(0, 99) < 25);
      r_fl    = ($urandom_range(0, 99) < 5);
      r_rdy   = ($urandom_range(0, 99) < 55);
      r_bpc   = $urandom() & 32'hFFFF_FFFC;
      r_fpc   = $urandom() & 32'hFFFF_FFFC;
      applyStimulus(r_rst, r_stall, r_br, r_bpc, r_fl, r_fpc, r_rdy);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
